// File: rtl/vip_pkg.sv
// Shared definitions for the frame controller: register map, CTRL/STATUS bit
// positions, display-select encodings and the frame sequencing states.
package vip_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_THRESH = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_LINES  = 2'd3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_CONT   = 1;
   localparam int CTRL_SEL_LO = 2;
   localparam int CTRL_SEL_HI = 3;
   localparam int CTRL_IRQ_EN = 4;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_PEND  = 1;
   localparam int STAT_ARMED = 2;

   typedef enum logic [1:0] {
      SEL_RAW   = 2'd0,
      SEL_GRAY  = 2'd1,
      SEL_BIN   = 2'd2,
      SEL_BLACK = 2'd3
   } sel_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

endpackage

// File: rtl/vip_edge_det.sv
// Single-edge detector: compares the input against a registered copy and
// flags a rising (default) or falling transition in the same cycle.
module vip_edge_det #(
   parameter bit DETECT_FALL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic pulse
);

   logic sig_d_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_d_reg <= 1'b0;
      end else begin
         sig_d_reg <= sig;
      end
   end

   assign pulse = DETECT_FALL ? (~sig & sig_d_reg) : (sig & ~sig_d_reg);

endmodule

// File: rtl/vip_frame_ctrl.sv
// Frame-level controller: CPU register file with frame-boundary commit,
// single-shot / continuous sequencing, frame and line counting, display mux.
module vip_frame_ctrl
   import vip_pkg::*;
#(
   parameter int LINE_W = 11,
   parameter int FCNT_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   output logic [15:0] cfg_rdata,
   input  logic        raw_vsync,
   input  logic        raw_hsync,
   input  logic        raw_de,
   input  logic [15:0] raw_rgb,
   input  logic        gray_vsync,
   input  logic        gray_hsync,
   input  logic        gray_de,
   input  logic [15:0] gray_rgb,
   input  logic        bin_vsync,
   input  logic        bin_hsync,
   input  logic        bin_de,
   input  logic [15:0] bin_rgb,
   output logic [7:0]  threshold,
   output logic        disp_vsync,
   output logic        disp_hsync,
   output logic        disp_de,
   output logic [15:0] disp_rgb,
   output logic        irq
);

   state_t              state_reg;
   logic                cont_reg;
   logic                irq_en_reg;
   sel_t                sel_shadow_reg;
   logic [7:0]          thr_shadow_reg;
   sel_t                sel_reg;
   logic [7:0]          threshold_reg;
   logic                pending_reg;
   logic [FCNT_W-1:0]   frame_cnt_reg;
   logic [LINE_W-1:0]   line_cnt_reg;
   logic [LINE_W-1:0]   lines_reg;

   logic fs;
   logic line_end;
   logic ctrl_wr;
   logic thr_wr;
   logic stat_wr;
   logic abort;

   vip_edge_det #(.DETECT_FALL(1'b0)) u_vsync_det (
      .clk   (clk),
      .rst   (rst),
      .sig   (raw_vsync),
      .pulse (fs)
   );

   vip_edge_det #(.DETECT_FALL(1'b1)) u_de_det (
      .clk   (clk),
      .rst   (rst),
      .sig   (raw_de),
      .pulse (line_end)
   );

   assign ctrl_wr = cfg_we && (cfg_addr == ADDR_CTRL);
   assign thr_wr  = cfg_we && (cfg_addr == ADDR_THRESH);
   assign stat_wr = cfg_we && (cfg_addr == ADDR_STATUS);
   // Clearing enable outside IDLE takes priority over any coincident frame start.
   assign abort   = ctrl_wr && !cfg_wdata[CTRL_EN] && (state_reg != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         cont_reg       <= 1'b0;
         irq_en_reg     <= 1'b0;
         sel_shadow_reg <= SEL_RAW;
         thr_shadow_reg <= 8'd0;
         sel_reg        <= SEL_RAW;
         threshold_reg  <= 8'd0;
         pending_reg    <= 1'b0;
         frame_cnt_reg  <= '0;
         line_cnt_reg   <= '0;
         lines_reg      <= '0;
      end else begin
         if (ctrl_wr) begin
            cont_reg       <= cfg_wdata[CTRL_CONT];
            irq_en_reg     <= cfg_wdata[CTRL_IRQ_EN];
            sel_shadow_reg <= sel_t'(cfg_wdata[CTRL_SEL_HI:CTRL_SEL_LO]);
         end
         if (thr_wr) begin
            thr_shadow_reg <= cfg_wdata[7:0];
         end
         if (stat_wr && cfg_wdata[STAT_PEND]) begin
            pending_reg <= 1'b0;
         end

         // Commits read the shadow registers' current values, so a same-cycle
         // CTRL/THRESH write only lands for the following frame.
         if (abort) begin
            state_reg <= IDLE;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (ctrl_wr && cfg_wdata[CTRL_EN]) begin
                     state_reg <= ARMED;
                  end
               end
               ARMED: begin
                  if (fs) begin
                     threshold_reg <= thr_shadow_reg;
                     sel_reg       <= sel_shadow_reg;
                     line_cnt_reg  <= '0;
                     state_reg     <= ACTIVE;
                  end
               end
               ACTIVE: begin
                  if (fs) begin
                     lines_reg     <= line_cnt_reg;
                     frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
                     pending_reg   <= 1'b1;
                     threshold_reg <= thr_shadow_reg;
                     sel_reg       <= sel_shadow_reg;
                     line_cnt_reg  <= '0;
                     if (!cont_reg) begin
                        state_reg <= IDLE;
                     end
                  end else if (line_end && (line_cnt_reg != '1)) begin
                     line_cnt_reg <= line_cnt_reg + LINE_W'(1);
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_vsync <= 1'b0;
         disp_hsync <= 1'b0;
         disp_de    <= 1'b0;
         disp_rgb   <= 16'd0;
      end else begin
         case (sel_reg)
            SEL_RAW: begin
               disp_vsync <= raw_vsync;
               disp_hsync <= raw_hsync;
               disp_de    <= raw_de;
               disp_rgb   <= raw_rgb;
            end
            SEL_GRAY: begin
               disp_vsync <= gray_vsync;
               disp_hsync <= gray_hsync;
               disp_de    <= gray_de;
               disp_rgb   <= gray_rgb;
            end
            SEL_BIN: begin
               disp_vsync <= bin_vsync;
               disp_hsync <= bin_hsync;
               disp_de    <= bin_de;
               disp_rgb   <= bin_rgb;
            end
            default: begin
               disp_vsync <= raw_vsync;
               disp_hsync <= raw_hsync;
               disp_de    <= raw_de;
               disp_rgb   <= 16'd0;
            end
         endcase
      end
   end

   always_comb begin
      cfg_rdata = 16'd0;
      case (cfg_addr)
         ADDR_CTRL: begin
            cfg_rdata[CTRL_EN]                 = (state_reg != IDLE);
            cfg_rdata[CTRL_CONT]               = cont_reg;
            cfg_rdata[CTRL_SEL_HI:CTRL_SEL_LO] = sel_shadow_reg;
            cfg_rdata[CTRL_IRQ_EN]             = irq_en_reg;
         end
         ADDR_THRESH: cfg_rdata[7:0] = thr_shadow_reg;
         ADDR_STATUS: begin
            cfg_rdata[STAT_BUSY]  = (state_reg == ACTIVE);
            cfg_rdata[STAT_PEND]  = pending_reg;
            cfg_rdata[STAT_ARMED] = (state_reg == ARMED);
            cfg_rdata[15:8]       = frame_cnt_reg[7:0];
         end
         default: cfg_rdata[LINE_W-1:0] = lines_reg;
      endcase
   end

   assign threshold = threshold_reg;
   assign irq       = pending_reg & irq_en_reg;

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Directed bench for vip_frame_ctrl: register access, frame sequencing,
// commit timing, display mux and same-cycle event priorities.
module tb_vip_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [15:0] cfg_wdata = 16'd0;
   logic [15:0] cfg_rdata;
   logic        raw_vsync = 1'b0, raw_hsync = 1'b0, raw_de = 1'b0;
   logic [15:0] raw_rgb = 16'd0;
   logic        gray_vsync = 1'b0, gray_hsync = 1'b0, gray_de = 1'b0;
   logic [15:0] gray_rgb = 16'd0;
   logic        bin_vsync = 1'b0, bin_hsync = 1'b0, bin_de = 1'b0;
   logic [15:0] bin_rgb = 16'd0;
   logic [7:0]  threshold;
   logic        disp_vsync, disp_hsync, disp_de;
   logic [15:0] disp_rgb;
   logic        irq;

   int checks = 0;
   int errors = 0;

   vip_frame_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .raw_vsync  (raw_vsync),
      .raw_hsync  (raw_hsync),
      .raw_de     (raw_de),
      .raw_rgb    (raw_rgb),
      .gray_vsync (gray_vsync),
      .gray_hsync (gray_hsync),
      .gray_de    (gray_de),
      .gray_rgb   (gray_rgb),
      .bin_vsync  (bin_vsync),
      .bin_hsync  (bin_hsync),
      .bin_de     (bin_de),
      .bin_rgb    (bin_rgb),
      .threshold  (threshold),
      .disp_vsync (disp_vsync),
      .disp_hsync (disp_hsync),
      .disp_de    (disp_de),
      .disp_rgb   (disp_rgb),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
      cfg_addr = a;
      #1;
      check(tag, cfg_rdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
      $display("write addr=%0d data=%h", a, d);
   endtask

   task automatic frame_start();
      raw_vsync = 1'b1;
      tick();
      raw_vsync = 1'b0;
      $display("frame start at %0t", $time);
   endtask

   task automatic lines(input int n);
      for (int i = 0; i < n; i++) begin
         raw_de = 1'b1;
         tick();
         tick();
         raw_de = 1'b0;
         tick();
      end
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_threshold", {8'd0, threshold}, 16'h0000);
      check("rst_irq", {15'd0, irq}, 16'h0000);
      check("rst_disp_rgb", disp_rgb, 16'h0000);
      chk_reg("rst_status", 2'd2, 16'h0000);
      chk_reg("rst_lines", 2'd3, 16'h0000);

      // Single-shot run: frame 1 armed by fs, completed by the next fs.
      wr(2'd1, 16'h0080);
      chk_reg("thresh_rd", 2'd1, 16'h0080);
      check("thr_before_fs", {8'd0, threshold}, 16'h0000);
      wr(2'd0, 16'h0001);
      chk_reg("ctrl_rd", 2'd0, 16'h0001);
      chk_reg("armed", 2'd2, 16'h0004);
      frame_start();
      tick();
      check("thr_commit", {8'd0, threshold}, 16'h0080);
      chk_reg("busy", 2'd2, 16'h0001);
      lines(4);
      chk_reg("lines_before", 2'd3, 16'h0000);
      frame_start();
      chk_reg("ss_lines", 2'd3, 16'h0004);
      chk_reg("ss_status", 2'd2, 16'h0102);
      chk_reg("ss_en_clr", 2'd0, 16'h0000);
      check("ss_irq_masked", {15'd0, irq}, 16'h0000);
      tick();
      lines(2);
      frame_start();
      tick();
      chk_reg("fs3_status", 2'd2, 16'h0102);
      chk_reg("fs3_lines", 2'd3, 16'h0004);
      wr(2'd2, 16'h0002);
      chk_reg("w1c", 2'd2, 16'h0100);

      // Continuous with irq: mid-frame THRESH write waits for the next fs.
      wr(2'd0, 16'h0013);
      chk_reg("cont_armed", 2'd2, 16'h0104);
      frame_start();
      tick();
      chk_reg("cont_busy", 2'd2, 16'h0101);
      lines(3);
      wr(2'd1, 16'h0040);
      tick();
      check("thr_hold", {8'd0, threshold}, 16'h0080);
      frame_start();
      check("thr_new", {8'd0, threshold}, 16'h0040);
      check("irq_high", {15'd0, irq}, 16'h0001);
      chk_reg("cont_lines", 2'd3, 16'h0003);
      chk_reg("cont_status", 2'd2, 16'h0203);
      wr(2'd2, 16'h0002);
      check("irq_drop", {15'd0, irq}, 16'h0000);
      chk_reg("cont_w1c", 2'd2, 16'h0201);

      // Display select: binary stream, then black with raw sync.
      lines(1);
      wr(2'd0, 16'h001B);
      frame_start();
      chk_reg("sel2_lines", 2'd3, 16'h0001);
      bin_de = 1'b1;
      bin_rgb = 16'hFFFF;
      raw_rgb = 16'h1111;
      tick();
      check("bin_rgb", disp_rgb, 16'hFFFF);
      check("bin_de", {15'd0, disp_de}, 16'h0001);
      bin_de = 1'b0;
      bin_rgb = 16'h0000;
      raw_rgb = 16'h0000;
      tick();
      lines(2);
      wr(2'd0, 16'h001F);
      frame_start();
      chk_reg("sel3_lines", 2'd3, 16'h0002);
      raw_hsync = 1'b1;
      raw_de = 1'b1;
      raw_rgb = 16'h1234;
      tick();
      check("black_rgb", disp_rgb, 16'h0000);
      check("black_hsync", {15'd0, disp_hsync}, 16'h0001);
      check("black_de", {15'd0, disp_de}, 16'h0001);
      raw_hsync = 1'b0;
      raw_de = 1'b0;
      raw_rgb = 16'h0000;
      tick();
      wr(2'd2, 16'h0002);
      chk_reg("pre_abort", 2'd2, 16'h0401);

      // Abort coinciding with fs while ACTIVE.
      raw_vsync = 1'b1;
      wr(2'd0, 16'h001E);
      raw_vsync = 1'b0;
      chk_reg("abort_status", 2'd2, 16'h0400);
      chk_reg("abort_lines", 2'd3, 16'h0002);
      chk_reg("abort_ctrl", 2'd0, 16'h001E);
      check("abort_thr", {8'd0, threshold}, 16'h0040);
      tick();

      // W1C coinciding with a completing fs: set wins.
      wr(2'd0, 16'h0013);
      chk_reg("rearm", 2'd2, 16'h0404);
      frame_start();
      tick();
      chk_reg("rearm_busy", 2'd2, 16'h0401);
      raw_vsync = 1'b1;
      wr(2'd2, 16'h0002);
      raw_vsync = 1'b0;
      chk_reg("set_wins", 2'd2, 16'h0503);
      check("set_wins_irq", {15'd0, irq}, 16'h0001);
      tick();

      // Reset pulse while ACTIVE.
      raw_hsync = 1'b1;
      tick();
      check("pre_rst_hsync", {15'd0, disp_hsync}, 16'h0001);
      rst = 1'b1;
      raw_hsync = 1'b0;
      #1;
      check("mid_rst_hsync", {15'd0, disp_hsync}, 16'h0000);
      check("mid_rst_thr", {8'd0, threshold}, 16'h0000);
      check("mid_rst_irq", {15'd0, irq}, 16'h0000);
      chk_reg("mid_rst_status", 2'd2, 16'h0000);
      chk_reg("mid_rst_lines", 2'd3, 16'h0000);
      chk_reg("mid_rst_ctrl", 2'd0, 16'h0000);
      tick();
      rst = 1'b0;
      tick();
      chk_reg("post_rst_status", 2'd2, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vip_frame_ctrl.md
# vip_frame_ctrl

Frame-level controller for the image-processing pipeline (RGB565 → gray → binary). It holds a CPU-written configuration, including the binarisation threshold and the display-stream select. Configuration is committed only on frame boundaries, so a frame never mixes settings. It sequences single-shot or continuous processing, counts frames and active lines, raises a frame-done interrupt, and muxes one of the three pipeline streams to the display.

## Interface
- LINE_W, 11: width of line counter (matches 11-bit xpos/ypos).
- FCNT_W, 16: width of frame counter.

- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  register write strobe (single cycle)
- cfg_addr  in  2  register index; 0 CTRL, 1 THRESH, 2 STATUS, 3 LINES
- cfg_wdata  in  16  write data
- cfg_rdata  out  16  combinational read of register at cfg_addr
- raw_vsync / raw_hsync / raw_de  in  1 each  camera-side sync (pipeline input)
- raw_rgb  in  16  RGB565 input pixel
- gray_vsync / gray_hsync / gray_de  in  1 each  gray-stage sync
- gray_rgb  in  16  gray pixel
- bin_vsync / bin_hsync / bin_de  in  1 each  binary-stage sync
- bin_rgb  in  16  binary pixel
- threshold  out  8  committed threshold to the binariser
- disp_vsync / disp_hsync / disp_de  out  1 each  selected stream sync, registered
- disp_rgb  out  16  selected stream pixel, registered
- irq  out  1  level; pending & irq_en

## Operation
- CTRL (R/W): bit0 enable, bit1 continuous, bits3:2 sel_shadow (0 raw, 1 gray, 2 bin, 3 black), bit4 irq_en; other bits read 0.
- THRESH (R/W): bits7:0 thr_shadow.
- STATUS: bit0 busy (state==ACTIVE), bit1 pending (write 1 clears), bit2 armed, bits15:8 frame_cnt[7:0]. Writes to other bits are ignored.
- LINES (RO): line count of the last completed frame, zero-extended.
- Frame start (fs) is a rising edge of raw_vsync, detected against a registered copy raw_vsync_d.
- Line end is a falling edge of raw_de, detected against raw_de_d.
- States:
  - IDLE: enable=0. Writing enable=1 → ARMED.
  - ARMED: on fs, commit shadows → ACTIVE; line_cnt cleared.
  - ACTIVE: line_cnt++ on each line end, saturating at all-ones.
- On fs while ACTIVE:
  - lines_reg ← line_cnt; frame_cnt++ (wraps); pending ← 1; commit shadows; line_cnt ← 0.
  - If continuous, stay ACTIVE.
  - Otherwise → IDLE and enable auto-clears.
- Writing enable=0 in ARMED or ACTIVE aborts → IDLE immediately: no pending, no count update, no commit.
- Commit: threshold ← thr_shadow, sel ← sel_shadow. Otherwise committed values never change.
- Display mux: by committed sel, register the chosen stream's vsync/hsync/de/rgb. sel=3 passes raw sync with rgb=0. The mux runs in every state.
- Simultaneous events:
  - Pending set and W1C in the same cycle: set wins.
  - CTRL write and fs in the same cycle: commit uses the pre-write shadow; the new shadow lands for the next frame.
  - Abort write in the same cycle as fs: abort wins.

## Timing
- Reset values: threshold=0, sel=0, all shadows 0, disp_* = 0, irq=0, frame_cnt=0, lines_reg=0, state IDLE.
- Edge detection: cycle N has raw_vsync=1, raw_vsync_d=0. State, commit, counters and pending update at the end of cycle N and are visible in N+1. threshold changes in N+1.
- Register writes take effect on the next cycle. cfg_rdata reflects state in the same cycle (no read side effects).
- Display path latency: exactly 1 clk from the selected input to disp_*. sel changes apply to inputs sampled from N+1.
- irq is combinational from registers; it rises in N+1 after a completing fs.

## Structure
- Shared package vip_pkg: register address constants, CTRL bit positions, sel encodings, state enum {IDLE, ARMED, ACTIVE}.
- One natural sub-module, vip_edge_det: registered rise/fall detector, instantiated for raw_vsync and raw_de.

## Test plan
- Reset mid-ACTIVE (rst pulsed) → all outputs at reset values next cycle; state IDLE; frame_cnt=0.
- Write THRESH=0x80, CTRL=0x01 (single-shot), then 3 frames of 4 lines each → threshold=0x80 from 1st fs+1. After 2nd fs: LINES=4, frame_cnt=1, pending=1, enable=0. 3rd fs causes no change.
- CTRL=0x13 (continuous, irq_en); write THRESH=0x40 mid-frame → threshold stays old until next fs, then 0x40. irq high; W1C STATUS=0x2 drops irq the next cycle.
- sel=2 committed; drive bin_rgb=0xFFFF with bin_de=1 → disp_rgb=0xFFFF and disp_de=1 one cycle later. sel=3 → disp_rgb=0 with raw sync passed through.
- Write CTRL enable=0 in the same cycle as fs while ACTIVE → IDLE; frame_cnt and LINES unchanged; pending=0.
- Write W1C in the same cycle as a completing fs → pending=1 afterwards.
